// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Brief    : Shared ALU datapath constants: operation encodings for the
//            adder/subtractor and bit positions for packed status flags.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Adder/subtractor operation select
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bit positions inside a packed 4-bit status word
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    // Packs individual status flags into the shared status-word layout
    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic z, input logic n);
        logic [3:0] flags;
        flags         = 4'b0000;
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
        flags[FLAG_Z] = z;
        flags[FLAG_N] = n;
        return flags;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla_slice
// Brief    : Combinational W-bit carry-lookahead adder slice. Carries inside
//            each GROUP-bit group are expanded as sums of generate terms;
//            groups are chained through block-level generate/propagate.
// Revision : 1.0 - initial release
// ============================================================================
module cla_slice #(
    parameter int W     = 8,
    parameter int GROUP = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    localparam int C_NGRP = W / GROUP;

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Per-bit carries from two-level lookahead: bit carries from the group
    // carry-in, group carry-out from block generate/propagate.
    always_comb begin
        logic v_gc;
        logic v_bg;
        logic v_bp;
        logic v_term;
        logic v_acc;
        w_c    = '0;
        v_gc   = cin;
        v_bg   = 1'b0;
        v_bp   = 1'b1;
        v_term = 1'b0;
        v_acc  = 1'b0;
        for (int j = 0; j < C_NGRP; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                // Group carry-in propagated through all lower bits of the group
                v_term = v_gc;
                for (int m = 0; m < i; m++) begin
                    v_term = v_term & w_p[j*GROUP+m];
                end
                v_acc = v_term;
                // Each lower bit's generate, propagated up to bit i
                for (int k = 0; k < i; k++) begin
                    v_term = w_g[j*GROUP+k];
                    for (int m = k + 1; m < i; m++) begin
                        v_term = v_term & w_p[j*GROUP+m];
                    end
                    v_acc = v_acc | v_term;
                end
                w_c[j*GROUP+i] = v_acc;
            end
            v_bg = 1'b0;
            v_bp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                v_bg = w_g[j*GROUP+i] | (w_p[j*GROUP+i] & v_bg);
                v_bp = v_bp & w_p[j*GROUP+i];
            end
            v_gc = v_bg | (v_bp & v_gc);
        end
        w_c[W] = v_gc;
    end

    assign sum      = w_p ^ w_c[W-1:0];
    assign cout     = w_c[W];
    assign c_msb_in = w_c[W-1];

endmodule : cla_slice
`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_addsub_pipe
// Brief    : Pipelined carry-lookahead adder/subtractor. The WIDTH-bit
//            operation is split into SEGMENTS slices, one per stage, with the
//            carry registered between stages. Valid/ready handshake with a
//            global stall; status flags produced in the last stage.
//            WIDTH must be a multiple of SEGMENTS*GROUP.
// Revision : 1.0 - initial release
// ============================================================================
module cla_addsub_pipe #(
    parameter int WIDTH    = 32,
    parameter int SEGMENTS = 4,
    parameter int GROUP    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    import alu_pkg::*;

    localparam int C_SW = WIDTH / SEGMENTS;

    logic                             w_advance;
    logic [WIDTH-1:0]                 w_b_eff;
    logic                             w_c_eff;

    // Stage-input buses: index k is what stage k consumes this cycle
    logic [SEGMENTS-1:0]              w_v;
    logic [SEGMENTS-1:0]              w_c;
    logic [SEGMENTS-1:0][WIDTH-1:0]   w_a;
    logic [SEGMENTS-1:0][WIDTH-1:0]   w_b;
    logic [SEGMENTS-1:0][WIDTH-1:0]   w_s;

    logic                             r_out_valid;
    logic [WIDTH-1:0]                 r_s;
    logic                             r_carry;
    logic                             r_ovf;
    logic                             r_zero;
    logic                             r_neg;

    // Whole pipe moves together; it only freezes when a result is waiting
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // Subtraction becomes a + ~b + !ci
    assign w_b_eff = (sub == OP_SUB) ? ~b  : b;
    assign w_c_eff = (sub == OP_SUB) ? ~ci : ci;

    assign w_v[0] = in_valid;
    assign w_a[0] = a;
    assign w_b[0] = w_b_eff;
    assign w_c[0] = w_c_eff;
    assign w_s[0] = '0;

    genvar k;
    generate
        for (k = 0; k < SEGMENTS; k++) begin : g_stage
            logic [C_SW-1:0]  w_sum;
            logic             w_cout;
            logic [WIDTH-1:0] w_res;

            // Merge this stage's slice into the partial result carried so far
            always_comb begin
                w_res = w_s[k];
                w_res[k*C_SW +: C_SW] = w_sum;
            end

            if (k < SEGMENTS - 1) begin : g_mid
                logic             w_cmsb_unused;
                logic             r_v;
                logic             r_c;
                logic [WIDTH-1:0] r_a;
                logic [WIDTH-1:0] r_b;
                logic [WIDTH-1:0] r_acc;

                cla_slice #(
                    .W     (C_SW),
                    .GROUP (GROUP)
                ) u_slice (
                    .a        (w_a[k][k*C_SW +: C_SW]),
                    .b        (w_b[k][k*C_SW +: C_SW]),
                    .cin      (w_c[k]),
                    .sum      (w_sum),
                    .cout     (w_cout),
                    .c_msb_in (w_cmsb_unused)
                );

                // Stage occupancy; cleared by reset so in-flight beats vanish
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_v <= 1'b0;
                    end else if (w_advance) begin
                        r_v <= w_v[k];
                    end
                end

                // Skew/deskew data; contents are don't-care while r_v is low
                always_ff @(posedge clk) begin
                    if (w_advance) begin
                        r_a   <= w_a[k];
                        r_b   <= w_b[k];
                        r_acc <= w_res;
                        r_c   <= w_cout;
                    end
                end

                assign w_v[k+1] = r_v;
                assign w_a[k+1] = r_a;
                assign w_b[k+1] = r_b;
                assign w_s[k+1] = r_acc;
                assign w_c[k+1] = r_c;
            end else begin : g_last
                logic             w_cmsb;
                // Lower operand slices were consumed by earlier stages
                logic [WIDTH-1:0] w_spent_unused;

                assign w_spent_unused = w_a[k] ^ w_b[k];

                cla_slice #(
                    .W     (C_SW),
                    .GROUP (GROUP)
                ) u_slice (
                    .a        (w_a[k][k*C_SW +: C_SW]),
                    .b        (w_b[k][k*C_SW +: C_SW]),
                    .cin      (w_c[k]),
                    .sum      (w_sum),
                    .cout     (w_cout),
                    .c_msb_in (w_cmsb)
                );

                // Output register: loads only on a valid beat so the result
                // and flags hold their last values across bubbles and stalls
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_out_valid <= 1'b0;
                        r_s         <= '0;
                        r_carry     <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_zero      <= 1'b0;
                        r_neg       <= 1'b0;
                    end else if (w_advance) begin
                        r_out_valid <= w_v[k];
                        if (w_v[k]) begin
                            r_s     <= w_res;
                            r_carry <= w_cout;
                            r_ovf   <= w_cmsb ^ w_cout;
                            r_zero  <= (w_res == '0);
                            r_neg   <= w_res[WIDTH-1];
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign carry     = r_carry;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign negative  = r_neg;

endmodule : cla_addsub_pipe
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_addsub_pipe
// Brief    : Directed self-checking bench for cla_addsub_pipe in three
//            configurations: 32/4/4, 16/2/4 and 32/1/4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_addsub_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        ci;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;

    logic        rdy_a, vld_a, c_a, v_a, z_a, n_a;
    logic [31:0] s_a;
    logic        rdy_b, vld_b, c_b, v_b, z_b, n_b;
    logic [15:0] s_b;
    logic        rdy_c, vld_c, c_c, v_c, z_c, n_c;
    logic [31:0] s_c;

    int          sel;
    int          lat;
    int          checks = 0;
    int          errors = 0;

    logic        o_rdy, o_vld, o_c, o_v, o_z, o_n;
    logic [31:0] o_s;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(32), .SEGMENTS(4), .GROUP(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(vld_a), .out_ready(out_ready), .s(s_a),
        .carry(c_a), .overflow(v_a), .zero(z_a), .negative(n_a)
    );

    cla_addsub_pipe #(.WIDTH(16), .SEGMENTS(2), .GROUP(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .a(a[15:0]), .b(b[15:0]), .ci(ci), .sub(sub),
        .out_valid(vld_b), .out_ready(out_ready), .s(s_b),
        .carry(c_b), .overflow(v_b), .zero(z_b), .negative(n_b)
    );

    cla_addsub_pipe #(.WIDTH(32), .SEGMENTS(1), .GROUP(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(vld_c), .out_ready(out_ready), .s(s_c),
        .carry(c_c), .overflow(v_c), .zero(z_c), .negative(n_c)
    );

    // Route the configuration under test onto one set of observation signals
    always_comb begin
        o_rdy = rdy_a; o_vld = vld_a; o_s = s_a;
        o_c = c_a; o_v = v_a; o_z = z_a; o_n = n_a;
        case (sel)
            1: begin
                o_rdy = rdy_b; o_vld = vld_b; o_s = {16'h0000, s_b};
                o_c = c_b; o_v = v_b; o_z = z_b; o_n = n_b;
            end
            2: begin
                o_rdy = rdy_c; o_vld = vld_c; o_s = s_c;
                o_c = c_c; o_v = v_c; o_z = z_c; o_n = n_c;
            end
            default: ;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_out_valid cfg=%0d got=%b exp=0", sel, o_vld); end
        checks++; if (o_s !== 32'h0) begin errors++; $display("FAIL reset_s cfg=%0d got=%h exp=0", sel, o_s); end
        checks++; if ({o_c, o_v, o_z, o_n} !== 4'b0000) begin errors++; $display("FAIL reset_flags cfg=%0d got=%b exp=0000", sel, {o_c, o_v, o_z, o_n}); end
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_ready cfg=%0d got=%b exp=1", sel, o_rdy); end
    endtask

    task automatic test_vectors;
        vec_t q[$];
        int   n;
        if (sel == 1) begin
            q.push_back('{32'h3,    32'h5,    1'b0, 1'b0, 32'h8,    1'b0, 1'b0, 1'b0, 1'b0});
            q.push_back('{32'h1,    32'hFFFF, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0});
            q.push_back('{32'h0,    32'hFFFF, 1'b0, 1'b0, 32'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
            q.push_back('{32'h7FFF, 32'h1,    1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
            q.push_back('{32'h5,    32'h3,    1'b0, 1'b1, 32'h2,    1'b1, 1'b0, 1'b0, 1'b0});
            q.push_back('{32'h3,    32'h5,    1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1});
            q.push_back('{32'h00FF, 32'h1,    1'b0, 1'b0, 32'h0100, 1'b0, 1'b0, 1'b0, 1'b0});
            q.push_back('{32'h8000, 32'h1,    1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0});
        end else begin
            q.push_back('{32'h3,        32'h5,        1'b0, 1'b0, 32'h8,        1'b0, 1'b0, 1'b0, 1'b0});
            q.push_back('{32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0});
            q.push_back('{32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
            q.push_back('{32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
            q.push_back('{32'h5,        32'h3,        1'b0, 1'b1, 32'h2,        1'b1, 1'b0, 1'b0, 1'b0});
            q.push_back('{32'h3,        32'h5,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1});
            q.push_back('{32'hA,        32'h14,       1'b1, 1'b0, 32'h1F,       1'b0, 1'b0, 1'b0, 1'b0});
            q.push_back('{32'hA,        32'h3,        1'b1, 1'b1, 32'h6,        1'b1, 1'b0, 1'b0, 1'b0});
            q.push_back('{32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
            q.push_back('{32'h0000FFFF, 32'h1,        1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0});
            q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1});
        end
        out_ready = 1'b1;
        foreach (q[i]) begin
            a = q[i].a; b = q[i].b; ci = q[i].ci; sub = q[i].sub;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n = 1;
            while (!o_vld && n < 20) begin
                tick();
                n++;
            end
            checks++; if (n != lat) begin errors++; $display("FAIL vec_latency cfg=%0d vec=%0d got=%0d exp=%0d", sel, i, n, lat); end
            checks++; if (o_s !== q[i].s) begin errors++; $display("FAIL vec_s cfg=%0d vec=%0d got=%h exp=%h", sel, i, o_s, q[i].s); end
            checks++; if ({o_c, o_v, o_z, o_n} !== {q[i].c, q[i].v, q[i].z, q[i].n}) begin
                errors++; $display("FAIL vec_flags_cvzn cfg=%0d vec=%0d got=%b exp=%b", sel, i, {o_c, o_v, o_z, o_n}, {q[i].c, q[i].v, q[i].z, q[i].n});
            end
            tick();
            checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL vec_no_dup cfg=%0d vec=%0d got=%b exp=0", sel, i, o_vld); end
            checks++; if (o_s !== q[i].s) begin errors++; $display("FAIL vec_hold_s cfg=%0d vec=%0d got=%h exp=%h", sel, i, o_s, q[i].s); end
        end
    endtask

    task automatic test_back_to_back;
        int idx = 0;
        out_ready = 1'b1; ci = 1'b0; sub = 1'b0;
        for (int t = 1; t <= 6 + lat + 2; t++) begin
            in_valid = (t <= 6);
            a = 32'h100 + 32'(t - 1);
            b = 32'(2 * (t - 1));
            tick();
            if (o_vld) begin
                checks++;
                if (o_s !== 32'h100 + 32'(3 * idx) || t != lat + idx) begin
                    errors++; $display("FAIL b2b_beat cfg=%0d idx=%0d got=%h@%0d exp=%h@%0d", sel, idx, o_s, t, 32'h100 + 32'(3 * idx), lat + idx);
                end
                idx++;
            end
        end
        in_valid = 1'b0;
        checks++; if (idx != 6) begin errors++; $display("FAIL b2b_count cfg=%0d got=%0d exp=6", sel, idx); end
    endtask

    task automatic test_backpressure;
        int pushed = 0;
        int got    = 0;
        out_ready = 1'b0; ci = 1'b0; sub = 1'b0;
        while (o_rdy && pushed < 20) begin
            in_valid = 1'b1;
            a = 32'h40 + 32'(pushed);
            b = 32'(pushed);
            tick();
            pushed++;
        end
        checks++; if (pushed != lat) begin errors++; $display("FAIL bp_fill cfg=%0d got=%0d exp=%0d", sel, pushed, lat); end
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            a = 32'h7777; b = 32'h1111 + 32'(t);
            tick();
            checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready cfg=%0d t=%0d got=%b exp=0", sel, t, o_rdy); end
            checks++; if (o_vld !== 1'b1 || o_s !== 32'h40) begin
                errors++; $display("FAIL bp_hold cfg=%0d t=%0d got=%b/%h exp=1/%h", sel, t, o_vld, o_s, 32'h40);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < lat + 6; g++) begin
            if (o_vld) begin
                checks++;
                if (o_s !== 32'h40 + 32'(2 * got)) begin
                    errors++; $display("FAIL bp_drain cfg=%0d idx=%0d got=%h exp=%h", sel, got, o_s, 32'h40 + 32'(2 * got));
                end
                got++;
            end
            tick();
        end
        checks++; if (got != pushed) begin errors++; $display("FAIL bp_count cfg=%0d got=%0d exp=%0d", sel, got, pushed); end
    endtask

    task automatic test_reset_midflight;
        int stale = 0;
        int n;
        out_ready = 1'b1; ci = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'h200 + 32'(i); b = 32'h0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_valid cfg=%0d got=%b exp=0", sel, o_vld); end
        for (int t = 0; t < lat + 3; t++) begin
            tick();
            if (o_vld) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale cfg=%0d got=%0d exp=0", sel, stale); end
        a = 32'h300; b = 32'h1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!o_vld && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n != lat || o_s !== 32'h301) begin
            errors++; $display("FAIL rst_mid_recover cfg=%0d got=%h@%0d exp=%h@%0d", sel, o_s, n, 32'h301, lat);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        sel = 0; lat = 4;
        for (int cfg = 0; cfg < 3; cfg++) begin
            sel = cfg;
            lat = (cfg == 0) ? 4 : (cfg == 1) ? 2 : 1;
            test_reset();
            test_vectors();
            test_back_to_back();
            test_backpressure();
            test_reset_midflight();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cla_addsub_pipe
`default_nettype wire
